// File: rtl/hazard_pkg.sv
// hazard_pkg: shared entry type, select-width helper and constants for reg_hazard_tracker
package hazard_pkg;
  localparam int HZ_ADDR_W = 5;
  localparam int SEL_REGFILE = 0;
  typedef struct packed {
    logic                 v;
    logic                 ld;
    logic [HZ_ADDR_W-1:0] dest;
  } hz_entry_t;
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/addr_match.sv
// addr_match: gated address equality; register 0 never matches
module addr_match #(
  parameter int ADDR_W = 5
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dest,
  output logic              match
);
  assign match = en & (src == dest) & (|src);
endmodule

// File: rtl/reg_hazard_tracker.sv
// reg_hazard_tracker: multi-stage destination tracker producing decode stall and forwarding selects
// Optional forwarding enabled by defining HAZ_FORWARD_EN (otherwise stall until producer retires)
module reg_hazard_tracker
  import hazard_pkg::*;
#(
  parameter int ADDR_W = HZ_ADDR_W,
  parameter int DEPTH = 3,
  parameter int NSRC = 2,
  parameter int CNT_W = 16,
  localparam int SEL_W = sel_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic                   issue_wen,
  input  logic                   issue_load,
  input  logic [ADDR_W-1:0]      issue_dest,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  input  logic                   flush,
  output logic                   stall,
  output logic [NSRC*SEL_W-1:0]  fwd_sel,
  output logic [CNT_W-1:0]       stall_count
);
  hz_entry_t ent [DEPTH];
  logic [NSRC-1:0][DEPTH-1:0] m;
  logic hit;
  genvar p, i;
  generate
    for (p = 0; p < NSRC; p++) begin : g_port
      for (i = 0; i < DEPTH; i++) begin : g_stage
        addr_match #(.ADDR_W(ADDR_W)) u_match (
          .en   (src_valid[p] & ent[i].v),
          .src  (src_addr[p*ADDR_W +: ADDR_W]),
          .dest (ent[i].dest),
          .match(m[p][i])
        );
      end
    end
  endgenerate
  // Scan oldest to youngest so the youngest matching stage overwrites the select
  always_comb begin
    fwd_sel = '0;
    hit = 1'b0;
    for (int q = 0; q < NSRC; q++) begin
`ifdef HAZ_FORWARD_EN
      hit = hit | (m[q][0] & ent[0].ld);
      for (int s = DEPTH - 1; s >= 0; s--)
        if (m[q][s]) fwd_sel[q*SEL_W +: SEL_W] = SEL_W'(s + 1);
`else
      hit = hit | (|m[q]);
`endif
    end
  end
  assign stall = issue_valid & ~flush & hit;
  always_ff @(posedge clk) begin
    if (reset) begin
      ent <= '{default: '0};
      stall_count <= '0;
    end else begin
      ent[0] <= '{v: issue_valid & issue_wen & ~stall & ~flush, ld: issue_load, dest: issue_dest};
      for (int s = 1; s < DEPTH; s++) ent[s] <= flush ? '0 : ent[s-1];
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule
